// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: two-requester round-robin front end feeding a single
// binary<->Gray converter with a one-entry output register.
module gray_conv_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_mode,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_mode,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    // Index of the requester granted in the most recent accepted transfer;
    // resets to 1 so that requester 0 wins the first contention.
    logic             last_grant_q, last_grant_d;

    logic             can_accept;
    logic             grant_vld;
    logic             grant_idx;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_mode;
    logic [WIDTH-1:0] conv_result;

    // Binary to Gray: the MSB passes through, every lower bit is the XOR
    // of itself and its upper neighbour.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        g[WIDTH-1] = b[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    // Gray to binary: a running XOR from the MSB downwards, each binary bit
    // depending on the already-decoded bit above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Round-robin grant: a lone requester always wins, under contention the
    // requester that was not granted last time wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_idx = ~last_grant_q;
        end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
        end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
        end
    end

    // Handshake: ready goes only to the granted requester and only when the
    // output register is free now or is being drained this cycle.
    always_comb begin
        accept     = can_accept && grant_vld;
        req0_ready = accept && (grant_idx == 1'b0);
        req1_ready = accept && (grant_idx == 1'b1);
    end

    // Operand mux and conversion of the granted request
    always_comb begin
        sel_data    = grant_idx ? req1_data : req0_data;
        sel_mode    = grant_idx ? req1_mode : req0_mode;
        conv_result = sel_mode ? gray2bin(sel_data) : bin2gray(sel_data);
    end

    // Occupancy state register; reset discards any pending result at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy: a new acceptance always fills, a drain without a
    // replacement empties, a stalled result stays put.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy-derived outputs
    always_comb begin
        out_valid  = (state_q == FULL);
        can_accept = (state_q == EMPTY) || out_ready;
    end

    // Result and arbitration history next-state: both change only on an
    // accepted transfer, so a drained result keeps its last value.
    always_comb begin
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_data_d   = conv_result;
            out_src_d    = grant_idx;
            last_grant_d = grant_idx;
        end
    end

    // Result and arbitration history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed scenarios plus
// randomized traffic checked by a queue-based scoreboard.
module tb_gray_conv_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_mode, req0_ready;
    logic [W-1:0] req0_data;
    logic         req1_valid, req1_mode, req1_ready;
    logic [W-1:0] req1_data;
    logic         out_valid, out_src, out_ready;
    logic [W-1:0] out_data;

    gray_conv_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_mode  (req0_mode),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_mode  (req1_mode),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         src;
    } res_t;

    res_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   m_valid;
    bit   m_last;
    int   wait0, wait1;

    // Reference conversion written with whole-word shifts
    function automatic logic [W-1:0] ref_conv(input logic [W-1:0] x, input logic mode);
        logic [W-1:0] r;
        if (!mode) begin
            r = x ^ (x >> 1);
        end else begin
            r = x;
            for (int s = 1; s < W; s++) r = r ^ (x >> s);
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic cycle(input logic v0, input logic [W-1:0] d0, input logic m0,
                         input logic v1, input logic [W-1:0] d1, input logic m1,
                         input logic ordy);
        bit can, gvld, g, e0, e1;
        req0_valid = v0; req0_data = d0; req0_mode = m0;
        req1_valid = v1; req1_data = d1; req1_mode = m1;
        out_ready  = ordy;
        #1;
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid && q.size() > 0) begin
            chk("held_data", int'(out_data), int'(q[0].data));
            chk("held_src", int'(out_src), int'(q[0].src));
        end
        can  = !m_valid || ordy;
        gvld = v0 || v1;
        g    = (v0 && v1) ? !m_last : !v0;
        e0   = can && gvld && !g;
        e1   = can && gvld && g;
        chk("req0_ready", int'(req0_ready), int'(e0));
        chk("req1_ready", int'(req1_ready), int'(e1));
        if (req0_ready) wait0 = 0;
        if (req1_ready) wait1 = 0;
        if (v0 && v1 && can) begin
            if (!req0_ready) wait0++;
            if (!req1_ready) wait1++;
            chk("no_starvation", int'(wait0 <= 1 && wait1 <= 1), 1);
        end
        if (can && gvld) begin
            q.push_back('{ref_conv(g ? d1 : d0, g ? m1 : m0), g});
            m_last  = g;
            m_valid = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset at a falling edge, checks the asynchronous clear, and
    // releases at a later falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_mode = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_mode = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_src", int'(out_src), 0);
        q.delete();
        m_valid = 1'b0;
        m_last  = 1'b1;
        wait0 = 0;
        wait1 = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every consumed result must be the oldest outstanding one
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result actual=data %0d src %0d required=no result", out_data, out_src);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    chk("mon_data", int'(out_data), int'(e.data));
                    chk("mon_src", int'(out_src), int'(e.src));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] b, g, held_d;
        logic         held_s;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_mode = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_mode = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // First transfer straight after reset release
        cycle(1'b1, 4'b1011, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("first_valid", int'(out_valid), 1);
        chk("first_data", int'(out_data), 4'b1110);
        chk("first_src", int'(out_src), 0);
        cycle(1'b0, '0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b1);
        chk("req1_g2b_data", int'(out_data), 4'b1011);
        chk("req1_g2b_src", int'(out_src), 1);

        // Exhaustive round trip through both modes
        for (int v = 0; v < (1 << W); v++) begin
            b = v[W-1:0];
            g = b ^ (b >> 1);
            cycle(1'b1, b, 1'b0, 1'b0, '0, 1'b0, 1'b1);
            cycle(1'b0, '0, 1'b0, 1'b1, g, 1'b1, 1'b1);
            chk("roundtrip", int'(out_data), v);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Continuous contention alternates starting with requester 0
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, W'($urandom), 1'($urandom), 1'b1, W'($urandom), 1'($urandom), 1'b1);
            chk("rr_valid", int'(out_valid), 1);
            chk("rr_src", int'(out_src), k % 2);
        end

        // Stall for five cycles under contention
        held_d = out_data;
        held_s = out_src;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, W'($urandom), 1'($urandom), 1'b1, W'($urandom), 1'($urandom), 1'b0);
            chk("stall_data", int'(out_data), int'(held_d));
            chk("stall_src", int'(out_src), int'(held_s));
            chk("stall_valid", int'(out_valid), 1);
        end
        cycle(1'b1, 4'b0001, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1);
        chk("after_stall_src", int'(out_src), int'(!held_s));

        // Asynchronous reset while holding a stalled result
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("pre_reset_valid", int'(out_valid), 1);
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
        chk("post_reset_data", int'(out_data), 4'b1000);
        chk("post_reset_src", int'(out_src), 1);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            cycle(1'(($urandom % 3) != 0), W'($urandom), 1'($urandom),
                  1'(($urandom % 3) != 0), W'($urandom), 1'($urandom),
                  1'(($urandom % 4) != 0));
        end

        // Drain and confirm nothing is left outstanding
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, data width of every data port; SHALL be at least 2.
REQ-002 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset; SHALL be asynchronous and active-low.
REQ-004 Port req0_valid, input, 1, requester 0 presents an operation.
REQ-005 Port req0_data, input, WIDTH, requester 0 operand.
REQ-006 Port req0_mode, input, 1, requester 0 operation: 0 = binary->Gray, 1 = Gray->binary.
REQ-007 Port req0_ready, output, 1, requester 0 operation accepted this cycle when high together with req0_valid.
REQ-008 Ports req1_valid, req1_data, req1_mode and req1_ready SHALL have the same directions, widths and meanings as their requester 0 counterparts, for requester 1.
REQ-009 Port out_valid, output, 1, result register holds a result.
REQ-010 Port out_data, output, WIDTH, converted result.
REQ-011 Port out_src, output, 1, requester index that produced out_data.
REQ-012 Port out_ready, input, 1, consumer accepts the result when high together with out_valid.

Function
REQ-013 Conversion: binary->Gray SHALL give g[W-1]=b[W-1] and g[i]=b[i+1]^b[i]; Gray->binary SHALL give b[W-1]=g[W-1] and b[i]=b[i+1]^g[i], with no carry or overflow.
REQ-014 Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 can_accept SHALL equal (!out_valid || out_ready), evaluated combinationally.
REQ-016 Arbitration: with only one valid requester, that requester SHALL be granted; with both valid, the requester not granted in the most recent accepted transfer SHALL be granted (round-robin); with neither valid, there SHALL be no grant.
REQ-017 reqN_ready SHALL be high only when can_accept is high and requester N is granted; it SHALL be combinational, and the ready of the non-granted requester SHALL be 0.
REQ-018 Accepted transfer: on the clock edge, out_data SHALL load the conversion of the granted data and mode, out_src SHALL load the grant index, out_valid SHALL become 1, and last_grant SHALL become the grant index; latency SHALL be 1 cycle from acceptance to out_valid.
REQ-019 FULL with out_ready=1 and no new grant: out_valid SHALL become 0, and out_data and out_src SHALL hold their values.
REQ-020 FULL with out_ready=1 and a new grant: the register SHALL be replaced in the same cycle and out_valid SHALL stay 1, giving full throughput of 1 result per cycle.
REQ-021 FULL with out_ready=0: out_data, out_src and out_valid SHALL hold stable, and both ready outputs SHALL be 0.
REQ-022 A requester whose valid is held low SHALL never be granted; a valid held while ready=0 SHALL NOT be counted as accepted.
REQ-023 last_grant SHALL change only on an accepted transfer.

Reset
REQ-024 While rst_n=0: out_valid=0, out_data=0, out_src=0, and last_grant=1, so requester 0 wins the first contention.
REQ-025 Assertion of rst_n mid-operation SHALL clear out_valid immediately, without waiting for clk, and any pending result SHALL be discarded.
REQ-026 The first accepted transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-027 Reset, then req0_valid=1, data=4'b1011, mode=0, with out_ready=1 -> req0_ready=1; next cycle out_valid=1, out_data=4'b1110, out_src=0.
REQ-028 req1 data=4'b1110, mode=1 -> out_data=4'b1011, out_src=1; exhaustive sweep of all 16 values in both modes, checking that each round-trip returns the original value.
REQ-029 Both requesters valid continuously, out_ready=1 -> grants alternate 0,1,0,1 starting with 0, with one result per cycle.
REQ-030 out_valid=1 held with out_ready=0 for 5 cycles while both requesters are valid -> outputs stable, both ready=0, and last_grant unchanged.
REQ-031 Drop rst_n while out_valid=1 and out_ready=0 -> out_valid=0 asynchronously; after release, req1 alone valid with data=4'b1111, mode=0 -> out_data=4'b1000.
REQ-032 Random valid/ready stimulus with a scoreboard -> no result lost or duplicated, per-requester order preserved, and no starvation beyond 1 cycle of contention.
